// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// interrupt_controller_pkg: shared constants and types for the interrupt controller.
// Revision: 1.0
package interrupt_controller_pkg;

  localparam int INTC_MAX_SRC = 8;
  localparam int INTC_IDX_W   = 3;

  localparam logic [1:0] INTC_CFG_MASK = 2'd0;
  localparam logic [1:0] INTC_CFG_EDGE = 2'd1;
  localparam logic [1:0] INTC_CFG_CLR  = 2'd2;

  typedef enum logic {
    INTC_IDLE = 1'b0,
    INTC_REQ  = 1'b1
  } intc_state_t;

endpackage
`default_nettype wire

// File: rtl/interrupt_controller_if.sv
`default_nettype none
// interrupt_controller_if: interrupt lines, config, microcode handshake and vector bus.
// Revision: 1.0
interface interrupt_controller_if #(
  parameter int NUM_SRC = 8
) ();
  logic [NUM_SRC-1:0] irq;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [7:0]         cfg_data;
  logic               int_ack;
  logic               eoi;
  logic               vector_n_out;
  logic               int_req;
  logic [7:0]         bus_out;
  logic               bus_oe;
  logic [NUM_SRC-1:0] in_service;

  modport master (
    output irq, cfg_we, cfg_sel, cfg_data, int_ack, eoi, vector_n_out,
    input  int_req, bus_out, bus_oe, in_service
  );

  modport slave (
    input  irq, cfg_we, cfg_sel, cfg_data, int_ack, eoi, vector_n_out,
    output int_req, bus_out, bus_oe, in_service
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_controller_prio_enc.sv
`default_nettype none
// intc_prio_enc: lowest-set-bit finder with a valid flag (index 0 wins).
// Revision: 1.0
module intc_prio_enc
  import interrupt_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]      vec,
  output logic [INTC_IDX_W-1:0] idx,
  output logic                  valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = INTC_IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// interrupt_controller: latches, prioritises and nests up to 8 interrupt sources.
// Revision: 1.0
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int         NUM_SRC      = 8,
  parameter logic [7:0] VECTOR_BASE  = 8'h40,
  parameter logic [7:0] SPURIOUS_VEC = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst,
  interrupt_controller_if.slave  bus
);

  logic [NUM_SRC-1:0]    sync1, sync2, sync_prev;
  logic [NUM_SRC-1:0]    pending, mask, edge_en, in_service;
  logic [7:0]            vector;
  intc_state_t           state;

  logic [NUM_SRC-1:0]    cfg_bits, in_service_post, elig, set_pend, ack_clr, cfg_clr;
  logic [INTC_IDX_W-1:0] elig_idx, isr_idx;
  logic                  elig_valid, isr_valid, cand_valid;

  assign cfg_bits = bus.cfg_data[NUM_SRC-1:0];

  // EOI retires the highest-priority in-service source before ACK arbitrates.
  assign in_service_post = bus.eoi ? (in_service & (in_service - NUM_SRC'(1))) : in_service;
  assign elig            = pending & ~mask;

  intc_prio_enc #(.WIDTH(NUM_SRC)) u_enc_elig (
    .vec   (elig),
    .idx   (elig_idx),
    .valid (elig_valid)
  );

  intc_prio_enc #(.WIDTH(NUM_SRC)) u_enc_isr (
    .vec   (in_service_post),
    .idx   (isr_idx),
    .valid (isr_valid)
  );

  assign cand_valid = elig_valid && (!isr_valid || (elig_idx < isr_idx));

  assign set_pend = (edge_en & sync2 & ~sync_prev) | (~edge_en & sync2 & ~in_service);
  assign ack_clr  = (bus.int_ack && cand_valid) ? (NUM_SRC'(1) << elig_idx) : '0;
  assign cfg_clr  = (bus.cfg_we && (bus.cfg_sel == INTC_CFG_CLR)) ? cfg_bits : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      sync_prev  <= '0;
      pending    <= '0;
      mask       <= '1;
      edge_en    <= '0;
      in_service <= '0;
      vector     <= SPURIOUS_VEC;
      state      <= INTC_IDLE;
    end else begin
      sync1     <= bus.irq;
      sync2     <= sync1;
      sync_prev <= sync2;
      // New events are OR-ed in last so they survive a same-cycle ACK or clear.
      pending    <= (pending & ~ack_clr & ~cfg_clr) | set_pend;
      in_service <= in_service_post | ack_clr;

      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          INTC_CFG_MASK: mask    <= cfg_bits;
          INTC_CFG_EDGE: edge_en <= cfg_bits;
          default: ;
        endcase
      end

      if (bus.int_ack) begin
        vector <= cand_valid ? (VECTOR_BASE + 8'(elig_idx)) : SPURIOUS_VEC;
        state  <= INTC_IDLE;
      end else begin
        case (state)
          INTC_IDLE: if (cand_valid)  state <= INTC_REQ;
          INTC_REQ:  if (!cand_valid) state <= INTC_IDLE;
          default:   state <= INTC_IDLE;
        endcase
      end
    end
  end

  assign bus.int_req    = (state == INTC_REQ);
  assign bus.bus_out    = vector;
  assign bus.bus_oe     = ~bus.vector_n_out;
  assign bus.in_service = in_service;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// tb_interrupt_controller: directed scenarios plus random traffic against a reference model.
// Revision: 1.0
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  interrupt_controller_if #(.NUM_SRC(8)) ifc ();

  interrupt_controller #(
    .NUM_SRC      (8),
    .VECTOR_BASE  (8'h40),
    .SPURIOUS_VEC (8'hFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state, advanced once per rising edge.
  bit [7:0] m_s1, m_s2, m_prev, m_pend, m_mask = 8'hFF, m_edge, m_isr, m_vec = 8'hFF;
  bit       m_req;
  bit       model_on = 1'b0;

  always @(posedge clk) begin : model
    bit [7:0] isr_post, set_now, new_pend;
    int       e, s;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_pend = 0; m_mask = 8'hFF;
      m_edge = 0; m_isr = 0; m_vec = 8'hFF; m_req = 0;
    end else begin
      isr_post = m_isr;
      if (ifc.eoi)
        for (int i = 0; i < 8; i++) if (isr_post[i]) begin isr_post[i] = 1'b0; break; end
      e = 8;
      for (int i = 0; i < 8; i++) if (m_pend[i] && !m_mask[i]) begin e = i; break; end
      s = 8;
      for (int i = 0; i < 8; i++) if (isr_post[i]) begin s = i; break; end
      for (int i = 0; i < 8; i++)
        set_now[i] = m_edge[i] ? (m_s2[i] && !m_prev[i]) : (m_s2[i] && !m_isr[i]);
      new_pend = m_pend;
      if (ifc.int_ack) begin
        if (e < s) begin
          m_vec       = 8'h40 + 8'(e);
          new_pend[e] = 1'b0;
          isr_post[e] = 1'b1;
        end else begin
          m_vec = 8'hFF;
        end
      end
      if (ifc.cfg_we) begin
        if (ifc.cfg_sel == 2'd0) m_mask = ifc.cfg_data;
        if (ifc.cfg_sel == 2'd1) m_edge = ifc.cfg_data;
        if (ifc.cfg_sel == 2'd2) new_pend = new_pend & ~ifc.cfg_data;
      end
      m_pend = new_pend | set_now;
      m_isr  = isr_post;
      m_req  = ifc.int_ack ? 1'b0 : (e < s);
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = ifc.irq;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_int_req", 32'(ifc.int_req), 32'(m_req));
      check("m_bus_out", 32'(ifc.bus_out), 32'(m_vec));
      check("m_in_service", 32'(ifc.in_service), 32'(m_isr));
      check("m_bus_oe", 32'(ifc.bus_oe), 32'(1'(~ifc.vector_n_out)));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] data);
    ifc.cfg_we = 1'b1; ifc.cfg_sel = sel; ifc.cfg_data = data;
    tick(1);
    ifc.cfg_we = 1'b0;
  endtask

  task automatic pulse_ack();
    ifc.int_ack = 1'b1; tick(1); ifc.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    ifc.eoi = 1'b1; tick(1); ifc.eoi = 1'b0;
  endtask

  initial begin
    ifc.irq = '0; ifc.cfg_we = 1'b0; ifc.cfg_sel = 2'd0; ifc.cfg_data = 8'h00;
    ifc.int_ack = 1'b0; ifc.eoi = 1'b0; ifc.vector_n_out = 1'b1;
    tick(2);
    model_on = 1'b1;
    check("rst_int_req", 32'(ifc.int_req), 32'h0);
    check("rst_bus_out", 32'(ifc.bus_out), 32'hFF);
    check("rst_in_service", 32'(ifc.in_service), 32'h00);
    rst = 1'b0;

    // Level source 3, latency and blocking while in service.
    cfg(INTC_CFG_MASK, 8'h00);
    ifc.irq = 8'h08;
    tick(3); check("s1_req_k2", 32'(ifc.int_req), 32'h0);
    tick(1); check("s1_req_k3", 32'(ifc.int_req), 32'h1);
    pulse_ack();
    check("s1_vec", 32'(ifc.bus_out), 32'h43);
    check("s1_isr", 32'(ifc.in_service), 32'h08);
    tick(2); check("s1_req_blocked", 32'(ifc.int_req), 32'h0);
    ifc.irq = 8'h00; tick(3);
    cfg(INTC_CFG_CLR, 8'hFF);
    pulse_eoi(); check("s1_isr_eoi", 32'(ifc.in_service), 32'h00);

    // Edge sources 5 and 2 together; 5 cannot preempt 2.
    cfg(INTC_CFG_EDGE, 8'hFF);
    ifc.irq = 8'h24;
    tick(4); check("s2_req", 32'(ifc.int_req), 32'h1);
    pulse_ack(); check("s2_vec2", 32'(ifc.bus_out), 32'h42);
    pulse_ack(); check("s2_spur", 32'(ifc.bus_out), 32'hFF);
    check("s2_isr_spur", 32'(ifc.in_service), 32'h04);
    pulse_eoi();
    pulse_ack(); check("s2_vec5", 32'(ifc.bus_out), 32'h45);
    check("s2_isr5", 32'(ifc.in_service), 32'h20);
    pulse_eoi(); ifc.irq = 8'h00; tick(3);

    // Nesting: 1 preempts 6.
    ifc.irq = 8'h40; tick(4); pulse_ack();
    check("s3_isr6", 32'(ifc.in_service), 32'h40);
    ifc.irq = 8'h42;
    tick(4); check("s3_req", 32'(ifc.int_req), 32'h1);
    pulse_ack(); check("s3_vec1", 32'(ifc.bus_out), 32'h41);
    check("s3_isr_nest", 32'(ifc.in_service), 32'h42);
    pulse_eoi(); check("s3_isr_eoi", 32'(ifc.in_service), 32'h40);
    pulse_eoi(); ifc.irq = 8'h00; tick(3);

    // Mask while requesting; pending is preserved.
    ifc.irq = 8'h08;
    tick(4); check("s4_req", 32'(ifc.int_req), 32'h1);
    cfg(INTC_CFG_MASK, 8'hFF);
    tick(1); check("s4_req_masked", 32'(ifc.int_req), 32'h0);
    cfg(INTC_CFG_MASK, 8'h00);
    tick(1); check("s4_req_unmask", 32'(ifc.int_req), 32'h1);
    pulse_ack(); check("s4_vec", 32'(ifc.bus_out), 32'h43);
    pulse_eoi(); ifc.irq = 8'h00; tick(3);

    // Edge beats CLR_PEND; EOI+ACK uses post-EOI in_service.
    ifc.irq = 8'h10; tick(2);
    cfg(INTC_CFG_CLR, 8'h10);
    tick(1); check("s5_edge_wins", 32'(ifc.int_req), 32'h1);
    pulse_ack(); check("s5_vec4", 32'(ifc.bus_out), 32'h44);
    ifc.irq = 8'h50;
    tick(4); check("s5_req_blocked", 32'(ifc.int_req), 32'h0);
    ifc.eoi = 1'b1; ifc.int_ack = 1'b1; tick(1); ifc.eoi = 1'b0; ifc.int_ack = 1'b0;
    check("s5_eoi_ack_vec", 32'(ifc.bus_out), 32'h46);
    check("s5_eoi_ack_isr", 32'(ifc.in_service), 32'h40);
    pulse_eoi(); ifc.irq = 8'h00; tick(3);

    // Reset mid-nest.
    ifc.irq = 8'h04; tick(4); pulse_ack();
    ifc.irq = 8'h05; tick(4); pulse_ack();
    check("s6_isr", 32'(ifc.in_service), 32'h05);
    rst = 1'b1; tick(1);
    check("s6_rst_req", 32'(ifc.int_req), 32'h0);
    check("s6_rst_vec", 32'(ifc.bus_out), 32'hFF);
    check("s6_rst_isr", 32'(ifc.in_service), 32'h00);
    rst = 1'b0; ifc.irq = 8'h00; tick(1);

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) ifc.irq[$urandom_range(0, 7)] ^= 1'b1;
      ifc.int_ack      = ($urandom_range(0, 5) == 0);
      ifc.eoi          = ($urandom_range(0, 6) == 0);
      ifc.cfg_we       = ($urandom_range(0, 11) == 0);
      ifc.cfg_sel      = 2'($urandom_range(0, 3));
      ifc.cfg_data     = 8'($urandom) & 8'($urandom);
      ifc.vector_n_out = 1'($urandom_range(0, 1));
      rst              = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    ifc.int_ack = 1'b0; ifc.eoi = 1'b0; ifc.cfg_we = 1'b0; rst = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
